btb_predictor: RTL and testbench

BTB_PREDICTOR -- requirements
Module: btb_predictor

---
 rtl/btb_predictor_pkg.sv | 34 +++
 rtl/btb_predictor_sat_counter.sv | 23 ++
 rtl/btb_predictor.sv | 145 ++++++++++++++
 tb/tb_btb_predictor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/btb_predictor_pkg.sv
// Shared types and defaults for the branch target buffer and the pipeline
// registers that carry its fetch-time hit index.
package btb_predictor_pkg;

  localparam int BTB_ENTRIES_DEFAULT = 4;
  localparam int BTB_CTR_W_DEFAULT   = 2;
  localparam int BTB_IDX_W_DEFAULT   = $clog2(BTB_ENTRIES_DEFAULT);

  typedef struct packed {
    logic                         valid;
    logic [29:0]                  tag;
    logic [31:0]                  target;
    logic [BTB_CTR_W_DEFAULT-1:0] ctr;
  } btb_entry_t;

  typedef struct packed {
    logic [31:0]                  pc;
    logic [31:0]                  instr;
    logic                         btb_hit;
    logic [BTB_IDX_W_DEFAULT-1:0] btb_hit_idx;
    logic                         prediction;
    logic [31:0]                  pred_target;
  } if_id_reg_t;

  typedef struct packed {
    logic [31:0]                  pc;
    logic [31:0]                  imm;
    logic                         btb_hit;
    logic [BTB_IDX_W_DEFAULT-1:0] btb_hit_idx;
    logic                         prediction;
    logic [31:0]                  pred_target;
  } id_ex_reg_t;

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Combinational saturating up/down counter used for the per-entry direction
// state of the branch target buffer.
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_in,
  input  logic             up,
  output logic [CTR_W-1:0] ctr_out
);

  // Step toward all-ones when taken, toward zero when not taken, clamping at both ends.
  always_comb begin
    ctr_out = ctr_in;
    if (up) begin
      if (ctr_in == {CTR_W{1'b1}}) ctr_out = ctr_in;
      else                         ctr_out = ctr_in + CTR_W'(1);
    end else begin
      if (ctr_in == {CTR_W{1'b0}}) ctr_out = ctr_in;
      else                         ctr_out = ctr_in - CTR_W'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Fully associative branch target buffer: combinational fetch lookup, EX-stage
// update/allocation with round-robin eviction, and a registered mispredict flag.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter  int ENTRIES = BTB_ENTRIES_DEFAULT,
  parameter  int CTR_W   = BTB_CTR_W_DEFAULT,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_pc,
  output logic             btb_hit,
  output logic [IDX_W-1:0] btb_hit_idx,
  output logic             prediction,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             flush_all,
  output logic             mispredict
);

  localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = CTR_W'(1) << (CTR_W - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [29:0]        tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               mispredict_q, mispredict_d;

  logic               hit_s, upd_hit_s, free_found_s;
  logic [IDX_W-1:0]   hit_idx_s, upd_idx_s, free_idx_s, alloc_idx_s;
  logic [CTR_W-1:0]   ctr_next_s;
  logic               ent_we_s;
  logic [IDX_W-1:0]   ent_idx_s;
  logic [31:0]        ent_target_s;
  logic [CTR_W-1:0]   ent_ctr_s;
  logic               unused_pc_lsb_s;

  // Tags cover pc[31:2]; the byte-offset bits never take part in matching.
  assign unused_pc_lsb_s = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Fetch, update and free-slot searches; descending scan leaves the lowest index.
  always_comb begin
    hit_s        = 1'b0;
    hit_idx_s    = '0;
    upd_hit_s    = 1'b0;
    upd_idx_s    = '0;
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == fetch_pc[31:2])) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
      end else begin
        hit_s     = hit_s;
      end
      if (valid_q[i] && (tag_q[i] == upd_pc[31:2])) begin
        upd_hit_s = 1'b1;
        upd_idx_s = IDX_W'(i);
      end else begin
        upd_hit_s = upd_hit_s;
      end
      if (!valid_q[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  assign alloc_idx_s = free_found_s ? free_idx_s : rr_q;

  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .ctr_in  (ctr_q[upd_idx_s]),
    .up      (upd_taken),
    .ctr_out (ctr_next_s)
  );

  // Next-state for valid bits, replacement pointer, entry write port and mispredict.
  always_comb begin
    valid_d      = valid_q;
    rr_d         = rr_q;
    mispredict_d = 1'b0;
    ent_we_s     = 1'b0;
    ent_idx_s    = upd_idx_s;
    ent_target_s = target_q[upd_idx_s];
    ent_ctr_s    = ctr_next_s;
    if (rst || flush_all) begin
      valid_d = '0;
      rr_d    = '0;
    end else if (upd_valid && upd_hit_s) begin
      ent_we_s = 1'b1;
      if (upd_taken) ent_target_s = upd_target;
      else           ent_target_s = target_q[upd_idx_s];
      mispredict_d = (ctr_q[upd_idx_s][CTR_W-1] != upd_taken) ||
                     (upd_taken && (target_q[upd_idx_s] != upd_target));
    end else if (upd_valid && upd_taken) begin
      ent_we_s               = 1'b1;
      ent_idx_s              = alloc_idx_s;
      ent_target_s           = upd_target;
      ent_ctr_s              = CTR_WEAK_TAKEN;
      valid_d[alloc_idx_s]   = 1'b1;
      mispredict_d           = 1'b1;
      // Only an eviction moves the pointer; filling an empty slot leaves it.
      if (free_found_s) rr_d = rr_q;
      else              rr_d = rr_q + IDX_W'(1);
    end else begin
      valid_d = valid_q;
    end
  end

  // Control state: valid bits, replacement pointer and the registered mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      rr_q         <= '0;
      mispredict_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Entry payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (ent_we_s) begin
      tag_q[ent_idx_s]    <= upd_pc[31:2];
      target_q[ent_idx_s] <= ent_target_s;
      ctr_q[ent_idx_s]    <= ent_ctr_s;
    end
  end

  assign btb_hit     = hit_s;
  assign btb_hit_idx = hit_idx_s;
  assign prediction  = hit_s & ctr_q[hit_idx_s][CTR_W-1];
  assign pred_target = hit_s ? target_q[hit_idx_s] : 32'h0000_0000;
  assign mispredict  = mispredict_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench: three BTB configurations share one stimulus stream and are
// compared against a per-configuration behavioural model.
module tb_btb_predictor;

  localparam int NCFG = 3;
  localparam int NE [NCFG] = '{4, 2, 16};
  localparam int CW [NCFG] = '{2, 1, 3};

  logic        clk = 1'b0;
  logic        rst, upd_valid, upd_taken, flush_all;
  logic [31:0] fetch_pc, upd_pc, upd_target;

  logic        hit_a, pred_a, mis_a;
  logic [1:0]  idx_a;
  logic [31:0] tgt_a;
  logic        hit_b, pred_b, mis_b;
  logic [0:0]  idx_b;
  logic [31:0] tgt_b;
  logic        hit_c, pred_c, mis_c;
  logic [3:0]  idx_c;
  logic [31:0] tgt_c;

  always #5 clk = ~clk;

  btb_predictor #(.ENTRIES(4), .CTR_W(2)) u_a (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .btb_hit(hit_a), .btb_hit_idx(idx_a),
    .prediction(pred_a), .pred_target(tgt_a), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .flush_all(flush_all), .mispredict(mis_a));
  btb_predictor #(.ENTRIES(2), .CTR_W(1)) u_b (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .btb_hit(hit_b), .btb_hit_idx(idx_b),
    .prediction(pred_b), .pred_target(tgt_b), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .flush_all(flush_all), .mispredict(mis_b));
  btb_predictor #(.ENTRIES(16), .CTR_W(3)) u_c (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .btb_hit(hit_c), .btb_hit_idx(idx_c),
    .prediction(pred_c), .pred_target(tgt_c), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .flush_all(flush_all), .mispredict(mis_c));

  typedef struct {
    int          cfg;
    bit          hit;
    int          idx;
    bit          pred;
    logic [31:0] tgt;
    bit          mis;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: per configuration, a small table of entries.
  bit          mv   [NCFG][16];
  logic [29:0] mtag [NCFG][16];
  logic [31:0] mtgt [NCFG][16];
  int          mctr [NCFG][16];
  int          mrr  [NCFG];
  bit          mmis [NCFG];

  function automatic int m_find(int k, logic [31:0] pc);
    for (int i = 0; i < NE[k]; i++)
      if (mv[k][i] && mtag[k][i] == pc[31:2]) return i;
    return -1;
  endfunction

  task automatic m_reset(int k);
    for (int i = 0; i < 16; i++) mv[k][i] = 1'b0;
    mrr[k]  = 0;
    mmis[k] = 1'b0;
  endtask

  task automatic m_apply(int k, bit r, bit fl, bit uv, logic [31:0] pc, bit tk, logic [31:0] tg);
    int h;
    int slot;
    int maxc;
    bit pred_taken;
    maxc = (1 << CW[k]) - 1;
    if (r || fl) begin
      m_reset(k);
      return;
    end
    mmis[k] = 1'b0;
    if (!uv) return;
    h = m_find(k, pc);
    if (h >= 0) begin
      pred_taken = (mctr[k][h] >= (1 << (CW[k] - 1)));
      mmis[k] = (pred_taken != tk) || (tk && mtgt[k][h] != tg);
      if (tk) begin
        mctr[k][h] = (mctr[k][h] < maxc) ? mctr[k][h] + 1 : maxc;
        mtgt[k][h] = tg;
      end else begin
        mctr[k][h] = (mctr[k][h] > 0) ? mctr[k][h] - 1 : 0;
      end
    end else if (tk) begin
      mmis[k] = 1'b1;
      slot = -1;
      for (int i = 0; i < NE[k]; i++)
        if (!mv[k][i] && slot < 0) slot = i;
      if (slot < 0) begin
        slot   = mrr[k];
        mrr[k] = (mrr[k] + 1) % NE[k];
      end
      mv[k][slot]   = 1'b1;
      mtag[k][slot] = pc[31:2];
      mtgt[k][slot] = tg;
      mctr[k][slot] = 1 << (CW[k] - 1);
    end
  endtask

  // Drive one cycle: queue expected outputs from pre-edge model state, then advance the model.
  task automatic step(bit r, logic [31:0] fpc, bit uv, logic [31:0] upc, bit tk,
                      logic [31:0] tg, bit fl);
    exp_t e;
    int   h;
    rst = r; fetch_pc = fpc; upd_valid = uv; upd_pc = upc;
    upd_taken = tk; upd_target = tg; flush_all = fl;
    for (int k = 0; k < NCFG; k++) begin
      h      = m_find(k, fpc);
      e.cfg  = k;
      e.hit  = (h >= 0);
      e.idx  = (h >= 0) ? h : 0;
      e.pred = (h >= 0) && (mctr[k][h] >= (1 << (CW[k] - 1)));
      e.tgt  = (h >= 0) ? mtgt[k][h] : 32'h0;
      e.mis  = mmis[k];
      sb_q.push_back(e);
      m_apply(k, r, fl, uv, upc, tk, tg);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cfg%0d @%0t: got %h expected %h", nm, k, $time, act, exp_v);
    end
  endtask

  // Monitor: pops each queued expectation mid-cycle and compares against the matching DUT.
  initial begin
    exp_t e;
    logic [31:0] a_hit, a_idx, a_pred, a_tgt, a_mis;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.cfg)
          0: begin a_hit = 32'(hit_a); a_idx = 32'(idx_a); a_pred = 32'(pred_a); a_tgt = tgt_a; a_mis = 32'(mis_a); end
          1: begin a_hit = 32'(hit_b); a_idx = 32'(idx_b); a_pred = 32'(pred_b); a_tgt = tgt_b; a_mis = 32'(mis_b); end
          default: begin a_hit = 32'(hit_c); a_idx = 32'(idx_c); a_pred = 32'(pred_c); a_tgt = tgt_c; a_mis = 32'(mis_c); end
        endcase
        chk("btb_hit",     e.cfg, a_hit,  32'(e.hit));
        chk("btb_hit_idx", e.cfg, a_idx,  32'(e.idx));
        chk("prediction",  e.cfg, a_pred, 32'(e.pred));
        chk("pred_target", e.cfg, a_tgt,  e.tgt);
        chk("mispredict",  e.cfg, a_mis,  32'(e.mis));
      end
    end
  end

  initial begin
    int wait_cycles;
    rst = 1'b1; fetch_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; flush_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NCFG; k++) m_reset(k);

    step(1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    step(1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
    repeat (3) step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h999, 1'b0);
    step(1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
    step(1'b0, 32'h70,  1'b1, 32'h70,  1'b1, 32'h300, 1'b1);
    step(1'b0, 32'h70,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
    step(1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
    for (int i = 1; i <= 6; i++)
      step(1'b0, 32'(i * 16), 1'b1, 32'(i * 16), 1'b1, 32'h400 + 32'(i), 1'b0);
    step(1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h50, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (5) step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h404, 1'b0);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h808, 1'b0);
    step(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0);
    step(1'b0, 32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0);
    step(1'b0, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0);

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] fpc, upc, tg;
      fpc = 32'h1000 + 32'($urandom_range(0, 23)) * 32'd4 + 32'($urandom_range(0, 3));
      upc = 32'h1000 + 32'($urandom_range(0, 23)) * 32'd4 + 32'($urandom_range(0, 3));
      tg  = 32'h2000 + 32'($urandom_range(0, 3)) * 32'd4;
      step(($urandom_range(0, 199) == 0), fpc, ($urandom_range(0, 9) < 7), upc,
           ($urandom_range(0, 9) < 6), tg, ($urandom_range(0, 59) == 0));
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
